// File: rtl/lzd_norm_pipe_if.sv
// Valid/ready bundle between the MAC accumulator, the normaliser and the rounder.
// "slave" is the normaliser's view; "master" is the view of the logic around it.
interface lzd_norm_pipe_if #(
  parameter int X_LEN   = 74,
  parameter int TAG_W   = 8,
  parameter int SHIFT_W = $clog2(X_LEN + 1)
);
  logic               valid_i;
  logic               ready_o;
  logic [X_LEN-1:0]   data_i;
  logic               mode_i;
  logic [TAG_W-1:0]   tag_i;
  logic               valid_o;
  logic               ready_i;
  logic [SHIFT_W-1:0] shift_num_o;
  logic [X_LEN-1:0]   norm_data_o;
  logic               allzero_o;
  logic [TAG_W-1:0]   tag_o;

  modport slave (
    input  valid_i, data_i, mode_i, tag_i, ready_i,
    output ready_o, valid_o, shift_num_o, norm_data_o, allzero_o, tag_o
  );

  modport master (
    output valid_i, data_i, mode_i, tag_i, ready_i,
    input  ready_o, valid_o, shift_num_o, norm_data_o, allzero_o, tag_o
  );
endinterface

// File: rtl/lzd_norm_pipe.sv
// Three-stage elastic leading-zero / leading-sign counter and left normaliser.
// S1 holds per-chunk zero flags and counts, S2 merges them, S3 shifts and drives the outputs.
module lzd_norm_pipe #(
  parameter int X_LEN   = 74,
  parameter int CHUNK   = 8,
  parameter int TAG_W   = 8,
  parameter int SHIFT_W = $clog2(X_LEN + 1)
) (
  input logic            clk_i,
  input logic            rst_i,
  lzd_norm_pipe_if.slave bus
);
  localparam int NCH = (X_LEN + CHUNK - 1) / CHUNK;
  localparam int CW  = $clog2(CHUNK + 1);

  logic               adv1, adv2, adv3;
  logic               s1_valid_reg, s2_valid_reg, s3_valid_reg;
  logic [X_LEN-1:0]   s1_data_reg, s2_data_reg, s3_norm_reg;
  logic [TAG_W-1:0]   s1_tag_reg, s2_tag_reg, s3_tag_reg;
  logic [NCH-1:0]     s1_zflag_reg, zflag_next;
  logic [NCH*CW-1:0]  s1_cnt_reg, cnt_next;
  logic [SHIFT_W-1:0] s2_shift_reg, s3_shift_reg, shift_next;
  logic               s2_allzero_reg, s3_allzero_reg;
  logic [X_LEN-1:0]   scan_word;
  logic [X_LEN-2:0]   rest_flip;
  logic               merge_done;

  assign adv3        = !s3_valid_reg || bus.ready_i;
  assign adv2        = !s2_valid_reg || adv3;
  assign adv1        = !s1_valid_reg || adv2;
  assign bus.ready_o = adv1;

  // Sign mode: bits matching the MSB become zeros, and a trailing 1 caps the count at X_LEN-1.
  assign rest_flip = bus.data_i[X_LEN-2:0] ^ {(X_LEN-1){bus.data_i[X_LEN-1]}};
  assign scan_word = bus.mode_i ? {rest_flip, 1'b1} : bus.data_i;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chunk
      localparam int HI = X_LEN - 1 - gi * CHUNK;
      localparam int W  = (HI + 1 < CHUNK) ? HI + 1 : CHUNK;
      logic [W-1:0]  bits;
      logic [CW-1:0] cnt_c;

      assign bits = scan_word[HI -: W];
      assign zflag_next[gi] = ~|bits;
      assign cnt_next[gi*CW +: CW] = cnt_c;

      always_comb begin
        cnt_c = CW'(W);
        for (int i = 0; i < W; i++) begin
          if (bits[i]) cnt_c = CW'(W - 1 - i);
        end
      end
    end
  endgenerate

  // Chunk counts add up until the first chunk that holds a one.
  always_comb begin
    shift_next = '0;
    merge_done = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (!merge_done) begin
        shift_next = shift_next + SHIFT_W'(s1_cnt_reg[c*CW +: CW]);
        if (!s1_zflag_reg[c]) merge_done = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (adv1 && bus.valid_i) begin
      s1_data_reg  <= bus.data_i;
      s1_tag_reg   <= bus.tag_i;
      s1_zflag_reg <= zflag_next;
      s1_cnt_reg   <= cnt_next;
    end
    if (adv2 && s1_valid_reg) begin
      s2_data_reg    <= s1_data_reg;
      s2_tag_reg     <= s1_tag_reg;
      s2_shift_reg   <= shift_next;
      s2_allzero_reg <= ~|s1_data_reg;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_reg   <= 1'b0;
      s2_valid_reg   <= 1'b0;
      s3_valid_reg   <= 1'b0;
      s3_shift_reg   <= '0;
      s3_norm_reg    <= '0;
      s3_allzero_reg <= 1'b0;
      s3_tag_reg     <= '0;
    end else begin
      if (adv1) s1_valid_reg <= bus.valid_i;
      if (adv2) s2_valid_reg <= s1_valid_reg;
      if (adv3) begin
        // A bubble entering S3 clears the output fields so idle outputs read zero.
        s3_valid_reg   <= s2_valid_reg;
        s3_shift_reg   <= s2_valid_reg ? s2_shift_reg : '0;
        s3_norm_reg    <= s2_valid_reg ? (s2_data_reg << s2_shift_reg) : '0;
        s3_allzero_reg <= s2_valid_reg && s2_allzero_reg;
        s3_tag_reg     <= s2_valid_reg ? s2_tag_reg : '0;
      end
    end
  end

  assign bus.valid_o     = s3_valid_reg;
  assign bus.shift_num_o = s3_shift_reg;
  assign bus.norm_data_o = s3_norm_reg;
  assign bus.allzero_o   = s3_allzero_reg;
  assign bus.tag_o       = s3_tag_reg;
endmodule

// File: tb/tb_lzd_norm_pipe.sv
// Bench for lzd_norm_pipe: a 74-bit and a 20-bit instance checked against a
// bit-serial reference model through per-instance scoreboards.
module tb_lzd_norm_pipe;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  lzd_norm_pipe_if #(.X_LEN(74), .TAG_W(8)) bus74 ();
  lzd_norm_pipe_if #(.X_LEN(20), .TAG_W(8)) bus20 ();

  lzd_norm_pipe #(.X_LEN(74), .CHUNK(8), .TAG_W(8)) u_dut74 (.clk_i(clk), .rst_i(rst_i), .bus(bus74));
  lzd_norm_pipe #(.X_LEN(20), .CHUNK(8), .TAG_W(8)) u_dut20 (.clk_i(clk), .rst_i(rst_i), .bus(bus20));

  typedef struct {
    logic [73:0] norm;
    int          shift;
    bit          az;
    logic [7:0]  tag;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          out_cnt[2];
  bit          lat_mode = 1'b0;
  bit          hold[2];
  logic [73:0] h_norm[2];
  int          h_shift[2];
  bit          h_az[2];
  logic [7:0]  h_tag[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic int qsize(input int w);
    return (w == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [73:0] mask_n(input int n);
    logic [73:0] one = 74'd1;
    return (one << n) - one;
  endfunction

  // Reference: walk bits from the top one at a time.
  function automatic int ref_shift(input logic [73:0] d, input int n, input bit m);
    int s = 0;
    bit stop = 1'b0;
    if (!m) begin
      for (int i = n - 1; i >= 0; i--) begin
        if (!stop) begin
          if (d[i]) stop = 1'b1;
          else s++;
        end
      end
    end else begin
      for (int i = n - 2; i >= 0; i--) begin
        if (!stop) begin
          if (d[i] == d[n-1]) s++;
          else stop = 1'b1;
        end
      end
    end
    return s;
  endfunction

  task automatic mon(input int w, input int n, input logic vi, input logic ro, input logic vo,
                     input logic ri, input logic [73:0] din, input logic md, input logic [7:0] tgi,
                     input int sh, input logic [73:0] nrm, input logic az, input logic [7:0] tgo);
    string p;
    exp_t e;
    logic [73:0] dm;
    int s;
    p = (w == 0) ? "x74" : "x20";
    chk({p, "_ready_o"}, ro, ri || (qsize(w) < 3));
    if (hold[w]) begin
      chk({p, "_stall_valid"}, vo, 1'b1);
      chk({p, "_stall_shift"}, sh, h_shift[w]);
      chk({p, "_stall_norm"}, nrm, h_norm[w]);
      chk({p, "_stall_az"}, az, h_az[w]);
      chk({p, "_stall_tag"}, tgo, h_tag[w]);
    end
    hold[w] = vo && !ri;
    h_shift[w] = sh; h_norm[w] = nrm; h_az[w] = az; h_tag[w] = tgo;
    if (vo && ri) begin
      out_cnt[w]++;
      if (qsize(w) == 0) begin
        tests++;
        assert (qsize(w) != 0) else begin
          fails++;
          $error("FAIL %s_spurious: observed output tag %0h expected no output", p, tgo);
        end
      end else begin
        e = (w == 0) ? q0.pop_front() : q1.pop_front();
        chk({p, "_shift"}, sh, e.shift);
        chk({p, "_norm"}, nrm, e.norm);
        chk({p, "_allzero"}, az, e.az);
        chk({p, "_tag"}, tgo, e.tag);
        if (e.lat) chk({p, "_latency"}, cyc - e.acc, 3);
      end
    end
    if (vi && ro) begin
      dm = din & mask_n(n);
      s = ref_shift(dm, n, md);
      e.shift = s;
      e.norm = (dm << s) & mask_n(n);
      e.az = (dm == '0);
      e.tag = tgi;
      e.acc = cyc;
      e.lat = lat_mode;
      if (w == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (rst_i) begin
      q0.delete();
      q1.delete();
      hold[0] = 1'b0;
      hold[1] = 1'b0;
    end else begin
      mon(0, 74, bus74.valid_i, bus74.ready_o, bus74.valid_o, bus74.ready_i, bus74.data_i,
          bus74.mode_i, bus74.tag_i, int'(bus74.shift_num_o), bus74.norm_data_o,
          bus74.allzero_o, bus74.tag_o);
      mon(1, 20, bus20.valid_i, bus20.ready_o, bus20.valid_o, bus20.ready_i, 74'(bus20.data_i),
          bus20.mode_i, bus20.tag_i, int'(bus20.shift_num_o), 74'(bus20.norm_data_o),
          bus20.allzero_o, bus20.tag_o);
    end
  end

  task automatic send(input int w, input logic [73:0] d, input bit m, input logic [7:0] t);
    bit ok = 1'b0;
    if (w == 0) begin
      bus74.valid_i = 1'b1; bus74.data_i = d; bus74.mode_i = m; bus74.tag_i = t;
    end else begin
      bus20.valid_i = 1'b1; bus20.data_i = d[19:0]; bus20.mode_i = m; bus20.tag_i = t;
    end
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if ((w == 0) ? bus74.ready_o : bus20.ready_o) ok = 1'b1;
    end
    tests++;
    assert (ok) else begin
      fails++;
      $error("FAIL send_timeout: observed ready_o low for 200 cycles expected accept, tag %0h", t);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int w);
    if (w == 0) bus74.valid_i = 1'b0;
    else bus20.valid_i = 1'b0;
  endtask

  task automatic drain(input int w);
    int g = 0;
    while (qsize(w) != 0 && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    chk((w == 0) ? "x74_drain" : "x20_drain", qsize(w), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [73:0] one74;
    logic [73:0] d;
    logic [95:0] r;
    int base, g;
    one74 = 74'd1;
    out_cnt[0] = 0; out_cnt[1] = 0;
    bus74.valid_i = 1'b0; bus74.data_i = '0; bus74.mode_i = 1'b0; bus74.tag_i = '0; bus74.ready_i = 1'b1;
    bus20.valid_i = 1'b0; bus20.data_i = '0; bus20.mode_i = 1'b0; bus20.tag_i = '0; bus20.ready_i = 1'b1;

    // Reset state
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_o", bus74.valid_o, 1'b0);
    chk("rst_shift", bus74.shift_num_o, 0);
    chk("rst_norm", bus74.norm_data_o, 0);
    chk("rst_allzero", bus74.allzero_o, 1'b0);
    chk("rst_tag", bus74.tag_o, 0);
    chk("rst_valid_o20", bus20.valid_o, 1'b0);
    rst_i = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready74", bus74.ready_o, 1'b1);
    chk("post_rst_ready20", bus20.ready_o, 1'b1);
    chk("idle_norm", bus74.norm_data_o, 0);

    // Directed words, back to back, latency checked
    lat_mode = 1'b1;
    send(0, one74 << 73, 1'b0, 8'h01);
    send(0, one74 << 72, 1'b0, 8'h02);
    send(0, one74, 1'b0, 8'h03);
    send(0, '0, 1'b0, 8'h5A);
    send(0, '1, 1'b1, 8'h11);
    d = 74'h3FF_0000_0000_0000_0000;
    send(0, d, 1'b1, 8'h12);
    send(0, one74 << 72, 1'b1, 8'h13);
    send(0, '0, 1'b1, 8'h14);
    idle(0);
    drain(0);
    lat_mode = 1'b0;

    // Backpressure: 10 words, ready_i low for 5 cycles after the 2nd output
    base = out_cnt[0];
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          r = {$urandom(), $urandom(), $urandom()};
          g = $urandom_range(0, 73);
          d = (one74 << g) | (r[73:0] & ((one74 << g) - one74));
          send(0, d, 1'b0, 8'(8'h20 + k));
        end
        idle(0);
      end
      begin
        for (int k = 0; k < 100 && out_cnt[0] < base + 2; k++) begin
          @(posedge clk); #1;
        end
        bus74.ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("x74_stall_ready_low", bus74.ready_o, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        bus74.ready_i = 1'b1;
      end
    join
    drain(0);
    chk("x74_bp_count", out_cnt[0] - base, 10);

    // Reset with three words in flight
    bus74.ready_i = 1'b0;
    send(0, one74 << 40, 1'b0, 8'h40);
    send(0, one74 << 30, 1'b0, 8'h41);
    send(0, one74 << 20, 1'b0, 8'h42);
    idle(0);
    chk("x74_full_ready", bus74.ready_o, 1'b0);
    base = out_cnt[0];
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    chk("midrst_valid_o", bus74.valid_o, 1'b0);
    chk("midrst_ready_o", bus74.ready_o, 1'b1);
    chk("midrst_tag", bus74.tag_o, 0);
    bus74.ready_i = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_output", out_cnt[0] - base, 0);

    // 20-bit instance: every single-bit position, corners and random words, both modes
    for (int m = 0; m < 2; m++) begin
      for (int p = 0; p < 20; p++) send(1, one74 << p, m[0], 8'(p));
      send(1, '0, m[0], 8'hE0);
      send(1, 74'hFFFFF, m[0], 8'hE1);
      for (int k = 0; k < 1000; k++) begin
        r = {$urandom(), $urandom(), $urandom()};
        d = 74'(r[19:0] >> $urandom_range(0, 19));
        if (m == 1 && $urandom_range(0, 1) == 1) d = ~d & 74'hFFFFF;
        send(1, d, m[0], 8'(k));
      end
    end
    idle(1);
    drain(1);

    chk("x74_final_empty", qsize(0), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lzd_norm_pipe.md
Name: lzd_norm_pipe

Overview:
- Parametrised, pipelined successor to the fixed-width combinational leading-one detector in the MAC datapath.
- Counts leading zeros (unsigned mode) or redundant sign bits (two's-complement mode) of an X_LEN-bit word, left-normalises the word by that count, and passes a sideband tag through unchanged.
- Sits between the MAC accumulator and the rounding stage.
- Uses a valid/ready elastic handshake on both sides, so the downstream rounder can stall it.

Parameters:
- X_LEN, 74: data width, >= 2.
- CHUNK, 8: width of each stage-1 zero-detect group; X_LEN need not be a multiple of CHUNK.
- TAG_W, 8: sideband tag width, >= 1.
- SHIFT_W, $clog2(X_LEN+1): shift-count width.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset, synchronous, active-high.
- valid_i  input  1  input word valid.
- ready_o  output  1  block can accept the input word this cycle.
- data_i  input  X_LEN  word to analyse.
- mode_i  input  1  0 = leading-one (unsigned), 1 = leading-sign (two's complement).
- tag_i  input  TAG_W  sideband, returned with the result.
- valid_o  output  1  result valid.
- ready_i  input  1  downstream accepts the result.
- shift_num_o  output  SHIFT_W  normalisation shift count.
- norm_data_o  output  X_LEN  data_i shifted left by shift_num_o, zero-filled.
- allzero_o  output  1  data_i was all zeros.
- tag_o  output  TAG_W  tag_i of the same transaction.

Behaviour:
- Single clock domain. Reset is synchronous and active-high, named rst_i; the clock is named clk_i.
- Three register stages, S1 to S3, each with its own valid bit:
  - S1: captures data, mode and tag. Computes per-CHUNK zero flags and the per-chunk leading count. Chunking starts at the MSB; any remainder chunk sits at the LSB end.
  - S2: merges the chunk results into shift count and allzero.
  - S3: applies the barrel left shift by the count and registers all outputs.
- Latency: a word accepted in cycle N appears on the outputs in cycle N+3 when there is no stall.
- Throughput: one word per cycle.
- Handshake:
  - A transfer in occurs when valid_i & ready_o; a transfer out occurs when valid_o & ready_i.
  - Stage k advances when it is empty or stage k+1 advances. S3 advances when it is empty or ready_i is high.
  - ready_o equals the S1 advance condition. It is combinational from ready_i and the stage valid bits; there is no combinational path from valid_i.
  - While valid_o is high and ready_i is low, all of valid_o, shift_num_o, norm_data_o, allzero_o and tag_o stay stable.
  - valid_i may drop without a transfer. Inputs are sampled only on a transfer.
- Mode 0 (leading-one):
  - shift_num_o equals the number of zero bits above the highest set bit, counted from bit X_LEN-1.
  - All-zero input gives shift_num_o = X_LEN, norm_data_o = 0, allzero_o = 1.
- Mode 1 (leading-sign):
  - shift_num_o equals the number of bits directly below bit X_LEN-1 that equal bit X_LEN-1, giving a range of 0 to X_LEN-1.
  - All-zero input gives X_LEN-1 with allzero_o = 1. All-ones input gives X_LEN-1 with allzero_o = 0.
- allzero_o is 1 exactly when data_i == 0, in both modes.
- norm_data_o is (data_i << shift_num_o) truncated to X_LEN bits. Shifting by X_LEN yields 0.
- Reset:
  - valid_o, all internal stage valid bits, shift_num_o, norm_data_o, allzero_o and tag_o go to 0.
  - ready_o is 1 from the first cycle after rst_i is released.
  - Reset asserted mid-stream discards all in-flight words; no partial output is produced.
  - Data registers need not be reset in non-valid stages, but outputs must read 0 while valid_o = 0 after reset.
- Simultaneous in and out transfers with the pipe full are sustained without a bubble.
- Words are returned in order, and each tag stays bound to its own word.

Test Plan:
- X_LEN=74, mode 0, data_i = 1<<73 then 1<<72 then 1<<0 back-to-back, ready_i=1:
  - shift_num_o = 0, 1, 73 on three consecutive cycles, starting 3 cycles after the first accept.
  - norm_data_o = 1<<73 each time.
- Mode 0, data_i = 0, tag 0x5A -> shift_num_o = 74, norm_data_o = 0, allzero_o = 1, tag_o = 0x5A.
- Mode 1:
  - data_i = all-ones -> shift 73, allzero_o = 0.
  - data_i = 74'h3FF_0000_0000_0000_0000 (bits 73:64 set) -> shift 9.
  - data_i = 1<<72 -> shift 0.
- Backpressure: stream 10 words with a random CHUNK-crossing leading-one position; hold ready_i = 0 for 5 cycles after the 2nd output:
  - ready_o falls once 3 words are stored.
  - Outputs stay stable while stalled.
  - All 10 words arrive in order with correct tags, and none is duplicated.
- Assert rst_i for 1 cycle while 3 words are in flight -> valid_o = 0 next cycle, none of the 3 words ever appears, ready_o = 1.
- Non-multiple width, X_LEN=20, CHUNK=8: exhaustively check every single-bit position and 1000 random words against a reference model in both modes.
